// File: rtl/cpu_run_controller.sv
// cpu_run_controller: run / halt / single-step sequencer for the CPU core.
// Produces a one-cycle cpu_en qualifier in the single clk domain, with a
// programmable rate divider in RUN and a wrapping executed-instruction count.
// Optional breakpoint halt is built when CPU_RUN_BREAKPOINT_EN is defined;
// otherwise bp_adrs/bp_valid are ignored and bp_hit is tied low.
module cpu_run_controller #(
  parameter int DIV_W = 24,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic [DIV_W-1:0] div_sel,
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_adrs,
  input  logic             bp_valid,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] inst_cnt,
  output logic             bp_hit
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_e;

  state_e           cur, nxt;
  logic [DIV_W-1:0] cnt;
  logic             step_prev;
  logic             first_tick;
  logic             step_rise;
  logic             tick;
  logic             bp_block;
  logic             enter_run;
  logic             enter_step;

  assign step_rise  = step_req & ~step_prev;
  // >= rather than == so a mid-run drop of div_sel ticks at once instead of wrapping
  assign tick       = (cur == S_RUN) && (cnt >= div_sel);
  assign enter_run  = (cur == S_HALT) && (nxt == S_RUN);
  assign enter_step = (cur == S_HALT) && (nxt == S_STEP);

`ifdef CPU_RUN_BREAKPOINT_EN
  logic bp_hit_q;

  // first_tick lets the instruction sitting on the breakpoint run after a resume
  assign bp_block = tick & bp_valid & (pc == bp_adrs) & ~first_tick;
  assign bp_hit   = bp_hit_q;

  // Sticky breakpoint flag, cleared whenever HALT is left
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  bp_hit_q <= 1'b0;
    else if (enter_run | enter_step) bp_hit_q <= 1'b0;
    else if (bp_block)             bp_hit_q <= 1'b1;
  end
`else
  logic bp_unused;

  assign bp_unused = ^{bp_valid, pc, bp_adrs, first_tick};
  assign bp_block  = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur <= S_HALT;
    else          cur <= nxt;
  end

  // Next state: halt beats run beats step; STEP always lasts one cycle
  always_comb begin
    nxt = cur;
    case (cur)
      S_HALT: begin
        if (halt_req)       nxt = S_HALT;
        else if (run_req)   nxt = S_RUN;
        else if (step_rise) nxt = S_STEP;
      end
      S_RUN:  if (halt_req | ~run_req | bp_block) nxt = S_HALT;
      S_STEP: nxt = S_HALT;
      default: nxt = S_HALT;
    endcase
  end

  // Outputs decoded from current state and prescale count
  always_comb begin
    cpu_en = 1'b0;
    state  = cur;
    if (cur == S_STEP)          cpu_en = 1'b1;
    else if (tick & ~bp_block)  cpu_en = 1'b1;
  end

  // Prescaler, first-tick flag, step edge history and instruction counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      first_tick <= 1'b0;
      step_prev  <= 1'b0;
      inst_cnt   <= '0;
    end else begin
      step_prev <= step_req;
      if (cpu_en) inst_cnt <= inst_cnt + CNT_W'(1);
      if (enter_run) begin
        cnt        <= '0;
        first_tick <= 1'b1;
      end else if (cur == S_RUN) begin
        if (tick) begin
          cnt        <= '0;
          first_tick <= 1'b0;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the sequencer rules.
module tb_cpu_run_controller;
  localparam int DIV_W = 24;
  localparam int CNT_W = 8;   // narrow counter so wrap-around is reachable
`ifdef CPU_RUN_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic             run_req, step_req, halt_req, bp_valid;
  logic [DIV_W-1:0] div_sel;
  logic [31:0]      pc, bp_adrs;
  logic             cpu_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] inst_cnt;
  logic             bp_hit;

  cpu_run_controller #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .div_sel(div_sel), .pc(pc), .bp_adrs(bp_adrs),
    .bp_valid(bp_valid), .cpu_en(cpu_en), .state(state), .inst_cnt(inst_cnt),
    .bp_hit(bp_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 halted, 1 running, 2 stepping; since = clocks since run start or last tick
  int m_mode, m_since, m_count;
  bit m_first, m_prev, m_hit;

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_cpu_en", cpu_en, 0);
      check("rst_state", state, 0);
      check("rst_inst_cnt", inst_cnt, 0);
      check("rst_bp_hit", bp_hit, 0);
      m_mode = 0; m_since = 0; m_count = 0; m_first = 0; m_prev = 0; m_hit = 0;
    end else begin
      bit tk, blk, en, rise;
      tk   = (m_mode == 1) && (m_since >= int'(div_sel));
      blk  = BP_EN && tk && bp_valid && (pc == bp_adrs) && !m_first;
      en   = (m_mode == 2) || (tk && !blk);
      check("cpu_en", cpu_en, en);
      check("state", state, m_mode);
      check("inst_cnt", inst_cnt, m_count);
      check("bp_hit", bp_hit, BP_EN ? m_hit : 1'b0);
      rise    = step_req && !m_prev;
      m_prev  = step_req;
      m_count = (m_count + int'(en)) % (1 << CNT_W);
      if (m_mode == 0) begin
        if (!halt_req && run_req) begin
          m_mode = 1; m_since = 0; m_first = 1; m_hit = 0;
        end else if (!halt_req && rise) begin
          m_mode = 2; m_hit = 0;
        end
      end else if (m_mode == 2) begin
        m_mode = 0;
      end else begin
        if (tk) begin m_since = 0; m_first = 0; end
        else m_since++;
        if (blk) m_hit = 1;
        if (halt_req || !run_req || blk) m_mode = 0;
      end
    end
  end

  // One clock; the pretend CPU advances pc on every enabled cycle
  bit last_en;
  task automatic cyc();
    @(negedge clk);
    last_en = cpu_en;
    @(posedge clk);
    #1;
    if (last_en) pc = pc + 1;
  endtask

  initial begin
    int n;
    reset_n = 0; run_req = 0; step_req = 0; halt_req = 0; bp_valid = 0;
    div_sel = '0; pc = 0; bp_adrs = 32'hFFFF_FFFF;
    repeat (3) cyc();
    reset_n = 1;
    repeat (20) cyc();
    check("idle_state", state, 0);
    check("idle_inst_cnt", inst_cnt, 0);

    // Divided run, then full rate
    div_sel = 3; run_req = 1;
    repeat (17) cyc();
    check("div3_inst_cnt", inst_cnt, 4);
    div_sel = 0;
    repeat (10) cyc();
    check("div0_inst_cnt", inst_cnt, 14);
    run_req = 0;
    cyc();
    check("run_exit_state", state, 0);
    check("run_exit_cnt", inst_cnt, 15);

    // Single step: one pulse per rising edge only
    step_req = 1;
    repeat (10) cyc();
    step_req = 0;
    repeat (3) cyc();
    check("step1_cnt", inst_cnt, 16);
    step_req = 1;
    repeat (15) cyc();
    check("step_hold_cnt", inst_cnt, 17);
    step_req = 0;
    cyc();

    // Mid-run reduction of div_sel, then halt
    div_sel = 9; run_req = 1;
    repeat (8) cyc();
    div_sel = 2;
    repeat (7) cyc();
    check("div_drop_cnt", inst_cnt, 20);
    halt_req = 1;
    cyc();
    check("halt_state", state, 0);
    check("halt_cnt", inst_cnt, 20);
    halt_req = 0; run_req = 0;
    cyc();

    // Counter wrap
    div_sel = 0; run_req = 1;
    repeat (301) cyc();
    check("wrap_cnt", inst_cnt, (20 + 300) % 256);
    run_req = 0;
    repeat (2) cyc();

    // Breakpoint at 0x10
    pc = 0; bp_adrs = 32'h10; bp_valid = 1; div_sel = 1; run_req = 1;
    cyc();
    n = 0;
    while (n < 200 && state != 0 && pc < 32'h14) begin cyc(); n++; end
    check("bp_loop_bounded", n < 200, 1);
    if (BP_EN) begin
      check("bp_halt_state", state, 0);
      check("bp_halt_pc", pc, 32'h10);
      check("bp_hit_set", bp_hit, 1);
      run_req = 0;
      cyc();
      check("bp_hit_sticky", bp_hit, 1);
      run_req = 1;
      repeat (4) cyc();
      check("bp_resume_hit", bp_hit, 0);
      check("bp_resume_pc", pc, 32'h11);
    end else begin
      check("nobp_state", state, 1);
      check("nobp_pc", pc, 32'h14);
      check("nobp_hit", bp_hit, 0);
    end
    run_req = 0; bp_valid = 0;
    repeat (2) cyc();

    // Randomized traffic with one asynchronous reset mid-run
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        bp_valid = 0; halt_req = 0; div_sel = 0; run_req = 1;
        repeat (3) cyc();
        check("pre_reset_en", cpu_en, 1);
        reset_n = 0;
        #1;
        check("async_rst_en", cpu_en, 0);
        check("async_rst_state", state, 0);
        check("async_rst_cnt", inst_cnt, 0);
        repeat (2) cyc();
        reset_n = 1;
      end
      if ($urandom_range(19) == 0) run_req = ~run_req;
      if ($urandom_range(3) == 0)  step_req = ~step_req;
      halt_req = ($urandom_range(15) == 0);
      if ($urandom_range(9) == 0)  div_sel = DIV_W'($urandom_range(4));
      if ($urandom_range(49) == 0) bp_valid = ~bp_valid;
      if ($urandom_range(29) == 0) bp_adrs = pc + $urandom_range(5);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
